divider_16bit_seq_ctrl: RTL
===========================

Name: divider_16bit_seq_ctrl

Overview:
- Sequencing stage wrapped around the combinational 16-by-8 divider (separate instance).
- Buffers divide requests in an input FIFO and drives the divider operands from the FIFO head.
- Captures the divider's quotient/remainder into an output register, with a valid/ready handshake on both sides.
- Adds tag passthrough and divide-by-zero handling; the divider itself needs no clock.

Parameters:
DEPTH, 4, input FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the request tag carried alongside operands.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
in_a  input  16  dividend.
in_b  input  8  divisor.
in_tag  input  TAG_W  request tag.
div_a  output  16  dividend to divider A.
div_b  output  8  divisor to divider B.
div_result  input  16  quotient from divider result.
div_odd  input  16  remainder from divider odd.
out_valid  output  1  response valid.
out_ready  input  1  consumer ready.
out_result  output  16  quotient.
out_odd  output  16  remainder.
out_tag  output  TAG_W  tag of the request.
out_dbz  output  1  divisor was zero.
fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries.
stat_ops  output  16  completed ops (see Optional Feature).
stat_dbz  output  16  divide-by-zero ops (see Optional Feature).

Behaviour:
- Reset (sync, rst=1 at edge):
  - FIFO pointers, fifo_count, out_valid, out_result, out_odd, out_tag, out_dbz and stats cleared to 0.
  - in_ready is forced 0 while rst=1.
  - Asserting reset mid-operation discards all queued and registered requests; there is no partial completion.
- FIFO:
  - in_ready = !rst && (fifo_count != DEPTH).
  - Push on in_valid && in_ready; stores {a, b, tag}.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - No push is possible when full, even if a pop happens in the same cycle.
- Operand drive:
  - div_a/div_b come combinationally from the FIFO head when fifo_count != 0.
  - When the FIFO is empty, both are 0.
- Output register (one-entry stage):
  - load = (fifo_count != 0) && (!out_valid || out_ready).
  - On load:
    - Pop the FIFO head and set out_valid = 1.
    - out_result <= div_result, out_odd <= div_odd, out_tag <= head tag, out_dbz <= (head b == 0).
  - If head b == 0: out_result forced 16'hFFFF, out_odd forced to head a, independent of the divider outputs.
  - Else if out_valid && out_ready with no load: out_valid <= 0.
  - Output fields hold their value while out_valid && !out_ready.
- Latency and throughput:
  - A request accepted at edge k into an empty FIFO, with the output stage free, gives out_valid = 1 after edge k+1.
  - Minimum latency is 2 cycles; with out_ready held high, sustained throughput is 1 op/cycle.
- Ordering: responses come out strictly in acceptance order.
- Arithmetic: unsigned. The quotient fits in 16 bits; the remainder is always < b (zero-extended to 16 bits) when b != 0.

Optional Feature:
- Macro DIV_STATS_EN.
- Defined:
  - stat_ops increments on each load; stat_dbz increments on each load with head b == 0.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: stat_ops and stat_dbz are tied to 0, no counter flops are present, and the port list is unchanged.

Test Plan:
- Reset then single request a=1000, b=7, tag=3 with out_ready=1 -> out_valid exactly 2 cycles after acceptance; result=142, odd=6, tag=3, dbz=0; fifo_count returns to 0.
- Divide by zero: a=16'h1234, b=0 -> result=16'hFFFF, odd=16'h1234, dbz=1; stat_dbz=1 with DIV_STATS_EN, 0 without.
- Backpressure: out_ready=0, push DEPTH+1 requests -> first loads into output register; in_ready drops after fifo_count reaches DEPTH; output held stable; release out_ready -> all DEPTH+1 responses delivered in order with correct tags.
- Streaming: out_ready=1, in_valid=1 for 20 cycles with a=65535..65516, b=255 -> one response/cycle after 2-cycle fill; e.g. 65535/255 -> result=257, odd=0.
- Mid-operation reset: 3 requests queued, rst pulsed 1 cycle -> out_valid=0, fifo_count=0 the cycle after; no stale response afterward; next request completes normally.
- Boundary: a=0, b=1 -> result=0, odd=0; a=65535, b=1 -> result=65535, odd=0.

Source files
------------

// File: rtl/divider_16bit_seq_ctrl.sv
// rtl/divider_16bit_seq_ctrl.sv - request FIFO + response register around a combinational 16/8 divider; DIV_STATS_EN enables op counters
module divider_16bit_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_a,
  input  logic [7:0]               in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [15:0]              div_a,
  output logic [7:0]               div_b,
  input  logic [15:0]              div_result,
  input  logic [15:0]              div_odd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [15:0]              out_odd,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_dbz,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              stat_ops,
  output logic [15:0]              stat_dbz
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]      mem_a   [DEPTH];
  logic [7:0]       mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic             not_empty;
  logic             push;
  logic             load;
  logic [15:0]      head_a;
  logic [7:0]       head_b;
  logic [TAG_W-1:0] head_tag;
  logic             head_dbz;

  // Handshake and head-of-queue decode; the full check ignores a same-cycle pop.
  always_comb begin
    not_empty = (fifo_count != '0);
    in_ready  = !rst && (fifo_count != CW'(DEPTH));
    push      = in_valid && in_ready;
    load      = not_empty && (!out_valid || out_ready);
    head_a    = mem_a[rd_ptr];
    head_b    = mem_b[rd_ptr];
    head_tag  = mem_tag[rd_ptr];
    head_dbz  = (head_b == 8'd0);
    div_a     = not_empty ? head_a : 16'd0;
    div_b     = not_empty ? head_b : 8'd0;
  end

  // Queue storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // One-entry response stage; a zero divisor bypasses the divider outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 16'd0;
      out_odd    <= 16'd0;
      out_tag    <= '0;
      out_dbz    <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_tag   <= head_tag;
      out_dbz   <= head_dbz;
      if (head_dbz) begin
        out_result <= 16'hFFFF;
        out_odd    <= head_a;
      end else begin
        out_result <= div_result;
        out_odd    <= div_odd;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DIV_STATS_EN
  // Saturating counters of loaded operations and of zero-divisor loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= 16'd0;
      stat_dbz <= 16'd0;
    end else if (load) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (head_dbz && (stat_dbz != 16'hFFFF)) stat_dbz <= stat_dbz + 16'd1;
    end
  end
`else
  assign stat_ops = 16'd0;
  assign stat_dbz = 16'd0;
`endif

endmodule
